// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART frame checker: FSM states and parity selects.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit the transmitter should have sent, given the XOR of all data bits.
  function automatic logic parityBit(input logic xorAll, input logic parType);
    case (parType)
      PAR_EVEN: return xorAll;
      PAR_ODD:  return ~xorAll;
      default:  return xorAll;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_checker_if.sv
// Bit-level receive interface between the line sampler (master) and the frame checker (slave).
// Optional error-counter signals appear only when UART_FRAME_ERR_CNT_EN is defined.
interface uart_frame_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic              frame_start;
  logic              bit_valid;
  logic              sampled_bit;
  logic              frame_abort;
  logic              par_en;
  logic              par_type;
  logic              stop2;
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              parity_error;
  logic              stop_error;
  logic              busy;
`ifdef UART_FRAME_ERR_CNT_EN
  logic              clr_cnt;
  logic [CNT_W-1:0]  par_err_cnt;
  logic [CNT_W-1:0]  stop_err_cnt;

  modport master (
    output frame_start, bit_valid, sampled_bit, frame_abort, par_en, par_type, stop2, clr_cnt,
    input  p_data, data_valid, parity_error, stop_error, busy, par_err_cnt, stop_err_cnt
  );
  modport slave (
    input  frame_start, bit_valid, sampled_bit, frame_abort, par_en, par_type, stop2, clr_cnt,
    output p_data, data_valid, parity_error, stop_error, busy, par_err_cnt, stop_err_cnt
  );
`else
  modport master (
    output frame_start, bit_valid, sampled_bit, frame_abort, par_en, par_type, stop2,
    input  p_data, data_valid, parity_error, stop_error, busy
  );
  modport slave (
    input  frame_start, bit_valid, sampled_bit, frame_abort, par_en, par_type, stop2,
    output p_data, data_valid, parity_error, stop_error, busy
  );
`endif

  if (DATA_W < 5 || DATA_W > 9 || CNT_W < 2 || CNT_W > 16) begin : g_bad_params
    $error("uart_frame_if: DATA_W must be 5..9 and CNT_W 2..16");
  end

endinterface

// File: rtl/uart_frame_checker_err_counter.sv
// Saturating error counter with priority clear; only compiled when UART_FRAME_ERR_CNT_EN is defined.
`ifdef UART_FRAME_ERR_CNT_EN
module uart_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/uart_frame_checker.sv
// UART receive frame checker: assembles data bits, checks parity and stop bits, flags errors per frame.
// Define UART_FRAME_ERR_CNT_EN to add saturating parity/stop error counters with a clear input.
module uart_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic         clk,
  input logic         rst,
  uart_frame_if.slave bus
);

  rx_state_e         state_q;
  logic [3:0]        bitCnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] pData_q;
  logic              parEn_q, parType_q, stop2_q;
  logic              parFlag_q, stopFlag_q;
  logic              dataValid_q, parErr_q, stopErr_q;

  logic lastDataBit;
  logic parityBad;
  logic stopBad;

  assign lastDataBit = (bitCnt_q == 4'(DATA_W - 1));
  assign parityBad   = (bus.sampled_bit != parityBit(^shift_q, parType_q));
  assign stopBad     = stopFlag_q | ~bus.sampled_bit;

  // Bits enter at the MSB and shift down, so after DATA_W strobes the first line bit sits at bit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      pData_q     <= '0;
      parEn_q     <= 1'b0;
      parType_q   <= 1'b0;
      stop2_q     <= 1'b0;
      parFlag_q   <= 1'b0;
      stopFlag_q  <= 1'b0;
      dataValid_q <= 1'b0;
      parErr_q    <= 1'b0;
      stopErr_q   <= 1'b0;
    end else begin
      dataValid_q <= 1'b0;
      if (state_q != IDLE && bus.frame_abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.frame_start) begin
              state_q    <= DATA;
              bitCnt_q   <= '0;
              shift_q    <= '0;
              parFlag_q  <= 1'b0;
              stopFlag_q <= 1'b0;
              parEn_q    <= bus.par_en;
              parType_q  <= bus.par_type;
              stop2_q    <= bus.stop2;
            end
          end
          DATA: begin
            if (bus.bit_valid) begin
              shift_q  <= {bus.sampled_bit, shift_q[DATA_W-1:1]};
              bitCnt_q <= bitCnt_q + 4'd1;
              if (lastDataBit) begin
                state_q <= parEn_q ? PARITY : STOP1;
              end
            end
          end
          PARITY: begin
            if (bus.bit_valid) begin
              if (parityBad) begin
                parFlag_q <= 1'b1;
              end
              state_q <= STOP1;
            end
          end
          STOP1: begin
            if (bus.bit_valid) begin
              if (stop2_q) begin
                stopFlag_q <= stopBad;
                state_q    <= STOP2;
              end else begin
                state_q     <= IDLE;
                dataValid_q <= 1'b1;
                pData_q     <= shift_q;
                parErr_q    <= parFlag_q;
                stopErr_q   <= stopBad;
              end
            end
          end
          STOP2: begin
            if (bus.bit_valid) begin
              state_q     <= IDLE;
              dataValid_q <= 1'b1;
              pData_q     <= shift_q;
              parErr_q    <= parFlag_q;
              stopErr_q   <= stopBad;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.p_data       = pData_q;
  assign bus.data_valid   = dataValid_q;
  assign bus.parity_error = parErr_q;
  assign bus.stop_error   = stopErr_q;
  assign bus.busy         = (state_q != IDLE);

`ifdef UART_FRAME_ERR_CNT_EN
  uart_err_counter #(.CNT_W(CNT_W)) u_par_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.clr_cnt),
    .inc_i (dataValid_q & parErr_q),
    .cnt_o (bus.par_err_cnt)
  );

  uart_err_counter #(.CNT_W(CNT_W)) u_stop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.clr_cnt),
    .inc_i (dataValid_q & stopErr_q),
    .cnt_o (bus.stop_err_cnt)
  );
`endif

  if (DATA_W < 5 || DATA_W > 9 || CNT_W < 2 || CNT_W > 16) begin : g_bad_params
    $error("uart_frame_checker: DATA_W must be 5..9 and CNT_W 2..16");
  end

endmodule
